// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between fetch (IF) and data access (DM).
// Define ARB_FAIR_EN to bound IF starvation with a DM-grant counter (limit STARVE_LIMIT).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must lie in 1..15");
  end

  state_e              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm;
  logic                arb_now;

  assign arb_now = (state_q == StIdle) && (if_req || dm_req);

`ifdef ARB_FAIR_EN
  logic [3:0] starve_q, starve_d;
  logic       if_turn;

  // IF takes one turn once DM has been granted STARVE_LIMIT times over a waiting fetch.
  assign if_turn  = if_req && (starve_q == 4'(STARVE_LIMIT));
  assign grant_dm = dm_req && !if_turn;

  always_comb begin
    starve_d = starve_q;
    if (arb_now) begin
      if (grant_dm && if_req) starve_d = starve_q + 4'd1;
      else                    starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (arb_now) begin
          state_d    = StIssue;
          owner_dm_d = grant_dm;
          if (grant_dm) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_be_d    = dm_be;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '0;
          end
        end
      end
      StIssue: begin
        if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StResp;
          // Write responses carry no data; keep the last read value visible.
          if (!mem_we_q) begin
            if (owner_dm_q) dm_rdata_d = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_dm_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = (state_q == StIssue);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = (state_q == StResp) && !owner_dm_q;
  assign dm_done   = (state_q == StResp) && owner_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder checks issued requests and a
// completion monitor checks *_done pulses against queued expectations.
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } mem_t;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    int          cyc;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_done, dm_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gnt_delay = 0;
  int   rv_delay = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;
  mem_t  exp_mem[$];
  done_t exp_done[$];

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_read(input bit is_dm, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] rdata, input int done_cyc);
    mem_t  m;
    done_t d;
    m.we = 1'b0; m.addr = addr; m.wdata = '0; m.be = is_dm ? be : 4'h0; m.rdata = rdata;
    d.is_dm = is_dm; d.rdata = rdata; d.cyc = done_cyc;
    exp_mem.push_back(m);
    exp_done.push_back(d);
    if (is_dm) exp_dm_rd = rdata;
    else       exp_if_rd = rdata;
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int done_cyc);
    mem_t  m;
    done_t d;
    // Responder returns junk data on writes; it must not reach dm_rdata.
    m.we = 1'b1; m.addr = addr; m.wdata = wdata; m.be = be; m.rdata = 32'hBAD0BAD0;
    d.is_dm = 1'b1; d.rdata = exp_dm_rd; d.cyc = done_cyc;
    exp_mem.push_back(m);
    exp_done.push_back(d);
  endtask

  task automatic wait_done(input bit is_dm, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (is_dm ? dm_done : if_done) break;
    end
    if (i == budget) chk(is_dm ? "timeout_dm_done" : "timeout_if_done", 1'b0, 1'b1);
  endtask

  task automatic wait_any(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_done || dm_done) break;
    end
    if (i == budget) chk("timeout_any_done", 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   '0);
    chk({tag, "_mem_we"},    32'(mem_we),    '0);
    chk({tag, "_mem_be"},    32'(mem_be),    '0);
    chk({tag, "_mem_addr"},  mem_addr,       '0);
    chk({tag, "_mem_wdata"}, mem_wdata,      '0);
    chk({tag, "_if_rdata"},  if_rdata,       '0);
    chk({tag, "_dm_rdata"},  dm_rdata,       '0);
    chk({tag, "_if_done"},   32'(if_done),   '0);
    chk({tag, "_dm_done"},   32'(dm_done),   '0);
  endtask

  // Memory responder: checks request fields on every issue cycle, then grants and responds.
  initial begin
    int   w;
    bit   busy;
    mem_t cur;
    w = 0; busy = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (busy) begin
        chk("mem_req_dropped", 32'(mem_req), '0);
        if (w == rv_delay) begin
          mem_rvalid = 1'b1; mem_rdata = cur.rdata; busy = 0; w = 0;
        end else w++;
      end else if (mem_req === 1'b1) begin
        if (exp_mem.size() == 0) chk("unexpected_mem_req", 32'(mem_req), '0);
        else begin
          chk("mem_we", 32'(mem_we), 32'(exp_mem[0].we));
          chk("mem_addr", mem_addr, exp_mem[0].addr);
          chk("mem_be", 32'(mem_be), 32'(exp_mem[0].be));
          if (exp_mem[0].we) chk("mem_wdata", mem_wdata, exp_mem[0].wdata);
          if (w == gnt_delay) begin
            mem_gnt = 1'b1; cur = exp_mem.pop_front(); busy = 1; w = 0;
          end else w++;
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      if (if_done === 1'b1 || dm_done === 1'b1) begin
        chk("done_exclusive", 32'(if_done & dm_done), '0);
        if (exp_done.size() == 0) chk("unexpected_done", 32'(if_done | dm_done), '0);
        else begin
          d = exp_done.pop_front();
          chk("done_port_dm", 32'(dm_done), 32'(d.is_dm));
          chk(d.is_dm ? "dm_rdata" : "if_rdata", d.is_dm ? dm_rdata : if_rdata, d.rdata);
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   k;
    logic is_dm;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DM read so that later writes have a nonzero dm_rdata to preserve.
    @(negedge clk); k = cyc;
    push_read(1, 32'h40, 4'h3, 32'hA5A50001, k + 3);
    dm_addr = 32'h40; dm_be = 4'h3; dm_we = 1'b0; dm_req = 1'b1;
    wait_done(1, 20); dm_req = 1'b0;

    // IF-only read, minimum latency.
    @(negedge clk); k = cyc;
    push_read(0, 32'h100, 4'h0, 32'hDEADBEEF, k + 3);
    if_addr = 32'h100; if_req = 1'b1;
    wait_done(0, 20); if_req = 1'b0;

    // DM write with grant held off for three cycles.
    @(negedge clk); k = cyc;
    gnt_delay = 3;
    push_write(32'h2000, 32'h12345678, 4'hF, k + 6);
    dm_addr = 32'h2000; dm_wdata = 32'h12345678; dm_be = 4'hF; dm_we = 1'b1; dm_req = 1'b1;
    wait_done(1, 20); dm_req = 1'b0; dm_we = 1'b0;
    gnt_delay = 0;

    // Simultaneous requests: DM first, then IF.
    @(negedge clk);
    rv_delay = 1;
    push_read(1, 32'h44, 4'hF, 32'h00001111, -1);
    push_read(0, 32'h104, 4'h0, 32'h22220000, -1);
    dm_addr = 32'h44; dm_be = 4'hF; if_addr = 32'h104;
    dm_req = 1'b1; if_req = 1'b1;
    wait_done(1, 30); dm_req = 1'b0;
    wait_done(0, 30); if_req = 1'b0;
    rv_delay = 0;

    // Both requesting continuously for six transactions.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FAIR_EN
      is_dm = (i % 3) != 2;
`else
      is_dm = 1'b1;
`endif
      if (is_dm) push_read(1, 32'h48, 4'hF, 32'h30000000 + 32'(i), -1);
      else       push_read(0, 32'h108, 4'h0, 32'h40000000 + 32'(i), -1);
    end
    dm_addr = 32'h48; if_addr = 32'h108; dm_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 6; i++) wait_any(30);
    dm_req = 1'b0; if_req = 1'b0;
    repeat (2) @(negedge clk);

    // DM request held through RESP re-arbitrates in the following IDLE.
    @(negedge clk); k = cyc;
    push_read(1, 32'h50, 4'hC, 32'h55555555, k + 3);
    push_read(1, 32'h50, 4'hC, 32'h66666666, k + 7);
    dm_addr = 32'h50; dm_be = 4'hC; dm_req = 1'b1;
    wait_done(1, 20);
    wait_done(1, 20); dm_req = 1'b0;

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clk); k = cyc;
    rv_delay = 3;
    begin
      mem_t m;
      m.we = 1'b0; m.addr = 32'h200; m.wdata = '0; m.be = 4'h0; m.rdata = 32'h77777777;
      exp_mem.push_back(m);
    end
    if_addr = 32'h200; if_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0;
    #2;
    check_all_zero("rst_in_wait");
    @(negedge clk); rst_n = 1'b1;
    exp_if_rd = '0; exp_dm_rd = '0;
    repeat (5) @(negedge clk);
    check_all_zero("after_late_rvalid");
    rv_delay = 0;

    // Fresh fetch after reset proves the FSM restarted from IDLE.
    @(negedge clk); k = cyc;
    push_read(0, 32'h204, 4'h0, 32'h0BADF00D, k + 3);
    if_addr = 32'h204; if_req = 1'b1;
    wait_done(0, 20); if_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("mem_queue_drained", 32'(exp_mem.size()), '0);
    chk("done_queue_drained", 32'(exp_done.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory port of the RISC-V core between the fetch stage (IF) and the data-memory access stage (DM). It accepts one request at a time from either side, runs a single outstanding transaction on the memory port with a grant/response handshake, and returns read data and a completion pulse to the requester. The pipeline stalls on the requester side until its `*_done` pulse arrives.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` bits.
- `STARVE_LIMIT`, 4: consecutive DM grants allowed while IF is waiting. Range 1–15. Used only with `ARB_FAIR_EN`.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high with stable `if_addr` until `if_done`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetch read data; valid while `if_done`=1 and held until the next IF completion.
- `if_done`  out  1  one-cycle fetch completion pulse.
- `dm_req`  in  1  data request; held with stable fields until `dm_done`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_be`  in  DATA_W/8  byte enables.
- `dm_rdata`  out  DATA_W  data read data; same validity rule as `if_rdata`.
- `dm_done`  out  1  one-cycle data completion pulse for reads and writes.
- `mem_req`  out  1  memory request; held until accepted.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  registered copies of the granted request.
- `mem_gnt`  in  1  memory accepts the request on an edge where `mem_req`=1 and `mem_gnt`=1.
- `mem_rvalid`  in  1  response strobe; reads and writes each produce exactly one.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_rvalid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: if either request is high, arbitrate, latch the winner's fields into the `mem_*` registers, record the owner, and go to ISSUE. Otherwise stay.
- Arbitration: DM wins over IF, because DM holds the older instruction. IF wins if only IF requests.
- ISSUE: `mem_req`=1 and the `mem_*` fields are stable. When `mem_gnt`=1, go to WAIT. `mem_req` drops on the following cycle.
- WAIT: when `mem_rvalid`=1, capture `mem_rdata` into the owner's rdata register (reads only; writes leave rdata unchanged) and go to RESP.
- RESP: the owner's `*_done`=1 for exactly this cycle. Requests are ignored in RESP. Next state is IDLE.
- A request that is still high in the cycle after RESP is treated as a new request.
- `mem_we`=0 and `mem_be`=0 are forced for IF transactions.
- `mem_rvalid` in IDLE, ISSUE or RESP is ignored.
- Reset (async, any state): state←IDLE. `mem_req`, `mem_we`, `mem_be`, `if_done`, `dm_done`←0. `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`←0. Fairness counter←0.
- A response arriving after reset is dropped (FSM is in IDLE).

## Timing
- Request seen high at edge N → `mem_req` high in cycle N+1.
- Minimum transaction: `mem_gnt` in N+1 and `mem_rvalid` in N+2 → `*_done` in N+3. Minimum latency is 3 cycles.
- Each extra `mem_gnt` or `mem_rvalid` wait cycle adds one cycle.
- Back-to-back throughput: one transaction per 4 cycles minimum (IDLE, ISSUE, WAIT, RESP).
- Simultaneous `if_req` and `dm_req` in IDLE: DM is granted, and IF is served in the next IDLE if it is still pending.

## Configuration
- `ARB_FAIR_EN` defined:
  - A 4-bit counter increments on each DM grant made while `if_req`=1.
  - When the counter equals `STARVE_LIMIT` and `if_req`=1, IF wins the next arbitration.
  - The counter clears on any IF grant, or on a DM grant made while `if_req`=0.
- `ARB_FAIR_EN` undefined: strict DM priority, and the counter is not built.

## Test plan
- IF-only read: `if_addr`=0x100, gnt immediate, rvalid one cycle later with rdata 0xDEADBEEF → `if_done` at N+3, `if_rdata`=0xDEADBEEF, `mem_we`=0.
- DM write with `mem_gnt` delayed 3 cycles: `dm_addr`=0x2000, `dm_wdata`=0x12345678, `dm_be`=0xF → `mem_*` fields stable for all 4 ISSUE cycles, `dm_done` once, `dm_rdata` unchanged.
- Simultaneous `if_req`+`dm_req` held → DM served first, then IF; exactly one `*_done` pulse each.
- `ARB_FAIR_EN`, `STARVE_LIMIT`=2, DM and IF continuously requesting → grant order DM, DM, IF, DM, DM, IF. Without the macro → DM only.
- Assert `rst_n`=0 in WAIT, release, then pulse `mem_rvalid` → no `*_done` pulse, all outputs 0, FSM in IDLE.
- Request held high through RESP → exactly one `*_done` per transaction and a second transaction starting the cycle after RESP.
